// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit ALU and its adder.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_ADC = 3'b001,
      OP_SUB = 3'b010,
      OP_SBC = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_SHL = 3'b111
   } op_t;

endpackage

// File: rtl/alu_iface.sv
// Bundle of ALU datapath signals used by the bench to drive and observe the ALU.
interface ALU_iface (input logic clock);

   logic [7:0] data_a;
   logic [7:0] data_b;
   logic [7:0] data_z;
   logic [3:0] flags_in;
   logic [3:0] flags_out;
   logic [2:0] operation;

endinterface

// File: rtl/alu_adder.sv
// Ripple-free behavioural adder shared by all four arithmetic operations.
// Subtraction is built by the caller as A + ~B + carry, so this block only
// needs an optional inversion of B and a plain carry-in.
module alu_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   input  logic             invert_b_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);

   logic [WIDTH-1:0] bEff;
   logic [WIDTH:0]   total;

   // Form the effective B operand and the full-width sum including carry out.
   always_comb begin
      bEff  = invert_b_i ? ~b_i : b_i;
      total = {1'b0, a_i} + {1'b0, bEff} + {{WIDTH{1'b0}}, carry_i};
      sum_o   = total[WIDTH-1:0];
      carry_o = total[WIDTH];
   end

endmodule

// File: rtl/alu.sv
// Combinational ALU with {N,Z,C,V} flags and a registered copy of its outputs.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       operation,
   input  logic [3:0]       flags_in,
   output logic [WIDTH-1:0] Z,
   output logic [3:0]       flags_out,
   output logic [WIDTH-1:0] Z_q,
   output logic [3:0]       flags_q
);

   op_t              opCode;
   logic             isSub;
   logic             adderCarryIn;
   logic [WIDTH-1:0] adderSum;
   logic             adderCarryOut;
   logic [WIDTH-1:0] zD;
   logic [3:0]       flagsD;

   assign opCode = op_t'(operation);

   // Select adder mode: subtraction inverts B and uses carry-in 1 minus the
   // incoming borrow, so SBC feeds the inverted C flag.
   always_comb begin
      isSub        = 1'b0;
      adderCarryIn = 1'b0;
      case (opCode)
         OP_ADC: adderCarryIn = flags_in[FLAG_C];
         OP_SUB: begin
            isSub        = 1'b1;
            adderCarryIn = 1'b1;
         end
         OP_SBC: begin
            isSub        = 1'b1;
            adderCarryIn = ~flags_in[FLAG_C];
         end
         default: begin
            isSub        = 1'b0;
            adderCarryIn = 1'b0;
         end
      endcase
   end

   alu_adder #(
      .WIDTH(WIDTH)
   ) u_adder (
      .a_i        (A),
      .b_i        (B),
      .carry_i    (adderCarryIn),
      .invert_b_i (isSub),
      .sum_o      (adderSum),
      .carry_o    (adderCarryOut)
   );

   // Result and flag generation; logic ops keep the incoming C and V.
   always_comb begin
      zD             = adderSum;
      flagsD         = flags_in;
      case (opCode)
         OP_ADD, OP_ADC: begin
            zD             = adderSum;
            flagsD[FLAG_C] = adderCarryOut;
            flagsD[FLAG_V] = (A[WIDTH-1] == B[WIDTH-1]) && (adderSum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB, OP_SBC: begin
            zD             = adderSum;
            flagsD[FLAG_C] = ~adderCarryOut;
            flagsD[FLAG_V] = (A[WIDTH-1] != B[WIDTH-1]) && (adderSum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: zD = A & B;
         OP_OR:  zD = A | B;
         OP_XOR: zD = A ^ B;
         OP_SHL: begin
            zD             = {A[WIDTH-2:0], 1'b0};
            flagsD[FLAG_C] = A[WIDTH-1];
            flagsD[FLAG_V] = A[WIDTH-1] ^ A[WIDTH-2];
         end
         default: zD = adderSum;
      endcase
      flagsD[FLAG_N] = zD[WIDTH-1];
      flagsD[FLAG_Z] = (zD == '0);
   end

   assign Z         = zD;
   assign flags_out = flagsD;

   // Pipeline register for downstream consumers; reset clears it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         Z_q     <= '0;
         flags_q <= 4'h0;
      end else begin
         Z_q     <= zD;
         flags_q <= flagsD;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the ALU, driven through ALU_iface.
module tb_alu;

   logic       clock;
   logic       reset;
   logic [7:0] zQ;
   logic [3:0] flagsQ;
   int         testsRun;
   int         testsFailed;

   ALU_iface bus (.clock(clock));

   alu dut (
      .clock     (bus.clock),
      .reset     (reset),
      .A         (bus.data_a),
      .B         (bus.data_b),
      .operation (bus.operation),
      .flags_in  (bus.flags_in),
      .Z         (bus.data_z),
      .flags_out (bus.flags_out),
      .Z_q       (zQ),
      .flags_q   (flagsQ)
   );

   // Free-running clock with a 10 time-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one operation away from the rising edge and let it settle.
   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [3:0] fin);
      @(negedge clock);
      bus.operation = op;
      bus.data_a    = a;
      bus.data_b    = b;
      bus.flags_in  = fin;
      #1;
   endtask

   // Single combinational vector: check result and flags.
   task automatic test_vector(input string name, input logic [2:0] op,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [3:0] fin, input logic [7:0] expZ,
                              input logic [3:0] expF);
      applyStimulus(op, a, b, fin);
      testsRun++;
      if (bus.data_z !== expZ) begin
         testsFailed++;
         $display("[TB] FAIL %s Z: got %02h expected %02h", name, bus.data_z, expZ);
      end
      testsRun++;
      if (bus.flags_out !== expF) begin
         testsFailed++;
         $display("[TB] FAIL %s flags: got %04b expected %04b", name, bus.flags_out, expF);
      end
   endtask

   // Reset clears the registers but leaves the combinational path alive.
   task automatic test_reset();
      reset = 1'b0;
      applyStimulus(3'b000, 8'h55, 8'h22, 4'h0);
      @(posedge clock);
      #1;
      testsRun++;
      if (zQ !== 8'h00 || flagsQ !== 4'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_regs: got Z_q=%02h flags_q=%04b expected 00/0000", zQ, flagsQ);
      end
      testsRun++;
      if (bus.data_z !== 8'h77) begin
         testsFailed++;
         $display("[TB] FAIL reset_comb Z: got %02h expected 77", bus.data_z);
      end
   endtask

   // After reset releases, the next edge captures the live result.
   task automatic test_registered();
      applyStimulus(3'b000, 8'h12, 8'h34, 4'h0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      testsRun++;
      if (zQ !== 8'h46 || flagsQ !== 4'h0) begin
         testsFailed++;
         $display("[TB] FAIL registered: got Z_q=%02h flags_q=%04b expected 46/0000", zQ, flagsQ);
      end
   endtask

   // ADD sweep of A with B=1; each result is also checked in Z_q one edge later.
   task automatic test_add_sweep();
      logic [7:0] expZ;
      for (int i = 0; i < 256; i++) begin
         expZ = 8'(i + 1);
         applyStimulus(3'b000, 8'(i), 8'h01, 4'h0);
         testsRun++;
         if (bus.data_z !== expZ) begin
            testsFailed++;
            $display("[TB] FAIL add_sweep A=%02h: got %02h expected %02h", i[7:0], bus.data_z, expZ);
         end
         if (i == 255) begin
            testsRun++;
            if (bus.flags_out !== 4'b0110) begin
               testsFailed++;
               $display("[TB] FAIL add_wrap flags: got %04b expected 0110", bus.flags_out);
            end
         end
         if (i == 127) begin
            testsRun++;
            if (bus.flags_out !== 4'b1001) begin
               testsFailed++;
               $display("[TB] FAIL add_ovf flags: got %04b expected 1001", bus.flags_out);
            end
         end
         @(posedge clock);
         #1;
         testsRun++;
         if (zQ !== expZ) begin
            testsFailed++;
            $display("[TB] FAIL add_sweep_q A=%02h: got %02h expected %02h", i[7:0], zQ, expZ);
         end
      end
   endtask

   task automatic test_arith();
      test_vector("add_ignores_c", 3'b000, 8'h01, 8'h01, 4'b0010, 8'h02, 4'b0000);
      test_vector("adc_v",         3'b001, 8'h7F, 8'h00, 4'b0010, 8'h80, 4'b1001);
      test_vector("adc_carry",     3'b001, 8'hFF, 8'h00, 4'b0010, 8'h00, 4'b0110);
      test_vector("sub_borrow",    3'b010, 8'h00, 8'h01, 4'b0000, 8'hFF, 4'b1010);
      test_vector("sub_ovf",       3'b010, 8'h80, 8'h01, 4'b0000, 8'h7F, 4'b0001);
      test_vector("sub_ignores_c", 3'b010, 8'h05, 8'h05, 4'b0010, 8'h00, 4'b0100);
      test_vector("sbc_plain",     3'b011, 8'h10, 8'h01, 4'b0010, 8'h0E, 4'b0000);
      test_vector("sbc_borrow",    3'b011, 8'h00, 8'h00, 4'b0010, 8'hFF, 4'b1010);
   endtask

   task automatic test_logic();
      test_vector("and_pass", 3'b100, 8'hF0, 8'h0F, 4'b0011, 8'h00, 4'b0111);
      test_vector("or",       3'b101, 8'h80, 8'h01, 4'b0000, 8'h81, 4'b1000);
      test_vector("xor",      3'b110, 8'hAA, 8'hAA, 4'b1010, 8'h00, 4'b0110);
   endtask

   task automatic test_shl();
      test_vector("shl_cv",   3'b111, 8'h81, 8'hFF, 4'b0000, 8'h02, 4'b0011);
      test_vector("shl_n",    3'b111, 8'h40, 8'h00, 4'b0011, 8'h80, 4'b1001);
   endtask

   // Run every scenario in order and report.
   initial begin
      testsRun      = 0;
      testsFailed   = 0;
      reset         = 1'b0;
      bus.data_a    = 8'h00;
      bus.data_b    = 8'h00;
      bus.flags_in  = 4'h0;
      bus.operation = 3'b000;
      test_reset();
      test_registered();
      test_add_sweep();
      test_arith();
      test_logic();
      test_shl();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
